exec_mem_unit: RTL and testbench

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

---
 rtl/exec_mem_unit.sv | 160 ++++++++++++++++
 tb/tb_exec_mem_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
//==============================================================================
// Module      : exec_mem_unit
// Description : RV32I control decode, ALU and word-addressed data RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module exec_mem_unit #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        branch,
    output logic        memread,
    output logic        memtoreg,
    output logic        alusrc,
    output logic        memwrite,
    output logic        regwrite,
    output logic [3:0]  aluctrl,
    output logic [31:0] alu_y,
    output logic        zero,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_data
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_SRA  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [3:0]      w_fn;
    logic [31:0]     w_b;
    logic [4:0]      w_shamt;
    logic [c_AW-1:0] w_idx;
    logic            w_unused_bits;

    logic [31:0]     r_mem [DEPTH];

    assign w_opcode      = instr[6:0];
    assign w_funct3      = instr[14:12];
    assign w_funct7      = instr[31:25];
    assign w_unused_bits = ^{instr[24:15], instr[11:7]};

    // Shared funct3 map for R- and I-type; instr[30] only matters for shifts here.
    always_comb begin
        w_fn = c_ALU_ADD;
        case (w_funct3)
            3'b000:  w_fn = c_ALU_ADD;
            3'b001:  w_fn = c_ALU_SLL;
            3'b010:  w_fn = c_ALU_SLT;
            3'b011:  w_fn = c_ALU_SLTU;
            3'b100:  w_fn = c_ALU_XOR;
            3'b101:  w_fn = instr[30] ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  w_fn = c_ALU_OR;
            default: w_fn = c_ALU_AND;
        endcase
    end

    always_comb begin
        branch   = 1'b0;
        memread  = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        aluctrl  = c_ALU_ADD;
        case (w_opcode)
            c_OP_R: begin
                if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) begin
                    regwrite = 1'b1;
                    aluctrl  = (w_funct3 == 3'b000 && instr[30]) ? c_ALU_SUB : w_fn;
                end
            end
            c_OP_I: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                aluctrl  = w_fn;
            end
            c_OP_LW: begin
                memread  = 1'b1;
                memtoreg = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            c_OP_SW: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
            end
            c_OP_BR: begin
                if (w_funct3 == 3'b000) begin
                    branch  = 1'b1;
                    aluctrl = c_ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    assign w_b     = alusrc ? imm : rs2_data;
    assign w_shamt = w_b[4:0];

    always_comb begin
        alu_y = 32'd0;
        case (aluctrl)
            c_ALU_ADD:  alu_y = rs1_data + w_b;
            c_ALU_SUB:  alu_y = rs1_data - w_b;
            c_ALU_AND:  alu_y = rs1_data & w_b;
            c_ALU_OR:   alu_y = rs1_data | w_b;
            c_ALU_XOR:  alu_y = rs1_data ^ w_b;
            c_ALU_SLL:  alu_y = rs1_data << w_shamt;
            c_ALU_SRL:  alu_y = rs1_data >> w_shamt;
            c_ALU_SRA:  alu_y = $unsigned($signed(rs1_data) >>> w_shamt);
            c_ALU_SLT:  alu_y = {31'd0, $signed(rs1_data) < $signed(w_b)};
            c_ALU_SLTU: alu_y = {31'd0, rs1_data < w_b};
            default:    alu_y = 32'd0;
        endcase
    end

    assign zero = (alu_y == 32'd0);

    // Word index wraps: address bits above and below the RAM window are dropped.
    assign w_idx = alu_y[c_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (memwrite) begin
            r_mem[w_idx] <= rs2_data;
        end
    end

    assign mem_rdata = memread ? r_mem[w_idx] : 32'd0;
    assign wb_data   = memtoreg ? mem_rdata : alu_y;

endmodule

`default_nettype wire

// File: tb/tb_exec_mem_unit.sv
//==============================================================================
// Module      : tb_exec_mem_unit
// Description : Self-checking bench for exec_mem_unit against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exec_mem_unit;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int NVEC  = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, rs1_data, rs2_data, imm;
    logic        branch, memread, memtoreg, alusrc, memwrite, regwrite, zero;
    logic [3:0]  aluctrl;
    logic [31:0] alu_y, mem_rdata, wb_data;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_mem [DEPTH];

    exec_mem_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .branch(branch), .memread(memread),
        .memtoreg(memtoreg), .alusrc(alusrc), .memwrite(memwrite),
        .regwrite(regwrite), .aluctrl(aluctrl), .alu_y(alu_y), .zero(zero),
        .mem_rdata(mem_rdata), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: classify the instruction, then compute the result arithmetically.
    function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] rb, input logic [31:0] im,
                                  output logic [5:0] ctl, output logic [3:0] ac,
                                  output logic [31:0] y);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] b;
        logic        is_r, is_i;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        is_r = (opc == 7'h33) && (f7 == 7'h00 || f7 == 7'h20);
        is_i = (opc == 7'h13);
        ctl  = 6'b0;   // {branch,memread,memtoreg,alusrc,memwrite,regwrite}
        ac   = 4'd0;
        y    = a + rb;
        if (is_r || is_i) begin
            b   = is_i ? im : rb;
            ctl = is_i ? 6'b000101 : 6'b000001;
            case (f3)
                3'd0: if (is_r && ins[30]) begin ac = 4'd1; y = a - b; end
                      else begin ac = 4'd0; y = a + b; end
                3'd1: begin ac = 4'd5; y = a << b[4:0]; end
                3'd2: begin ac = 4'd8; y = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                3'd3: begin ac = 4'd9; y = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin ac = 4'd4; y = a ^ b; end
                3'd5: if (ins[30]) begin ac = 4'd7; y = a >> b[4:0] | ~(32'hFFFFFFFF >> b[4:0]) & {32{a[31]}}; end
                      else begin ac = 4'd6; y = a >> b[4:0]; end
                3'd6: begin ac = 4'd3; y = a | b; end
                default: begin ac = 4'd2; y = a & b; end
            endcase
        end else if (opc == 7'h03) begin
            ctl = 6'b011101; y = a + im;
        end else if (opc == 7'h23) begin
            ctl = 6'b000110; y = a + im;
        end else if (opc == 7'h63 && f3 == 3'd0) begin
            ctl = 6'b100000; ac = 4'd1; y = a - rb;
        end
    endfunction

    always @(posedge clk) begin
        logic [5:0]  c;
        logic [3:0]  ac;
        logic [31:0] y;
        model(instr, rs1_data, rs2_data, imm, c, ac, y);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        end else if (c[1]) begin
            m_mem[y[AW+1:2]] = rs2_data;
        end
    end

    always @(negedge clk) begin
        logic [5:0]  c;
        logic [3:0]  ac;
        logic [31:0] y, rd;
        if (chk_en) begin
            model(instr, rs1_data, rs2_data, imm, c, ac, y);
            rd = c[4] ? m_mem[y[AW+1:2]] : 32'd0;
            check("ctrl", {26'd0, branch, memread, memtoreg, alusrc, memwrite, regwrite}, {26'd0, c});
            check("aluctrl", {28'd0, aluctrl}, {28'd0, ac});
            check("alu_y", alu_y, y);
            check("zero", {31'd0, zero}, {31'd0, (y == 32'd0)});
            check("mem_rdata", mem_rdata, rd);
            check("wb_data", wb_data, c[3] ? rd : y);
        end
    end

    task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        @(posedge clk);
        #1;
        rst = r; instr = ins; rs1_data = a; rs2_data = b; imm = im;
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] V_INS [NVEC] = '{
        32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020B1B3,
        32'h0020C1B3, 32'h0020D1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h402091B3,
        32'h022081B3, 32'hFFF08193, 32'hFFF0A193, 32'h4040D193, 32'h0040D193,
        32'h40008193, 32'h00209063, 32'h00000073};
    localparam logic [31:0] V_A [NVEC] = '{
        32'd3, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
        32'hF0F0F0F0, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1,
        32'd10, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'h80000000,
        32'd1, 32'd5, 32'd1};
    localparam logic [31:0] V_B [NVEC] = '{
        32'd5, 32'd33, 32'd1, 32'hFFFFFFFF, 32'd1,
        32'hFF00FF00, 32'd4, 32'h0F0F0000, 32'hFF00FF00, 32'd4,
        32'd20, 32'd7, 32'd0, 32'd0, 32'd0,
        32'd0, 32'd6, 32'd2};
    localparam logic [31:0] V_IMM [NVEC] = '{
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
        32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000404, 32'h00000004,
        32'h00000400, 32'd0, 32'd0};
    localparam logic [31:0] V_Y [NVEC] = '{
        32'hFFFFFFFE, 32'd2, 32'd1, 32'd1, 32'd0,
        32'h0FF00FF0, 32'h08000000, 32'hFFFFF0F0, 32'hF000F000, 32'd16,
        32'd30, 32'hFFFFFFFF, 32'd1, 32'hF8000000, 32'h08000000,
        32'h00000401, 32'd11, 32'd3};

    initial begin
        rst = 1'b1; instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
        @(posedge clk);
        @(posedge clk);
        chk_en = 1'b1;

        // Reset state: RAM reads back zero.
        drive(1'b0, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        check("reset_ram", mem_rdata, 32'd0);

        drive(1'b0, 32'h002081B3, 32'd5, 32'd7, 32'd0);
        check("add_ctl", {26'd0, regwrite, alusrc, aluctrl}, {26'd0, 2'b10, 4'b0000});
        check("add_y", alu_y, 32'd12);
        check("add_zero", {31'd0, zero}, 32'd0);
        check("add_wb", wb_data, 32'd12);

        drive(1'b0, 32'h4020D1B3, 32'h80000000, 32'd4, 32'd0);
        check("sra_ac", {28'd0, aluctrl}, 32'd7);
        check("sra_y", alu_y, 32'hF8000000);

        drive(1'b0, 32'h00208063, 32'h1234, 32'h1234, 32'd0);
        check("beq_br", {27'd0, branch, aluctrl}, {27'd0, 1'b1, 4'b0001});
        check("beq_y", alu_y, 32'd0);
        check("beq_zero", {31'd0, zero}, 32'd1);
        drive(1'b0, 32'h00208063, 32'h1234, 32'h1235, 32'd0);
        check("bne_zero", {31'd0, zero}, 32'd0);

        drive(1'b0, 32'h0020A423, 32'h100, 32'hDEADBEEF, 32'd8);
        drive(1'b0, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        check("lw_rdata", mem_rdata, 32'hDEADBEEF);
        check("lw_wb", wb_data, 32'hDEADBEEF);
        check("lw_mtr", {31'd0, memtoreg}, 32'd1);

        // Address wrap: 0x108 + 4*DEPTH aliases the same word.
        drive(1'b0, 32'h0080A183, 32'h100 + 32'd4 * DEPTH, 32'd0, 32'd8);
        check("lw_wrap", mem_rdata, 32'hDEADBEEF);

        drive(1'b1, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        drive(1'b0, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        check("rst_clear", mem_rdata, 32'd0);

        drive(1'b1, 32'h0020A423, 32'h100, 32'h55555555, 32'd8);
        check("rst_memwrite_comb", {31'd0, memwrite}, 32'd1);
        drive(1'b0, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        check("rst_blocks_sw", mem_rdata, 32'd0);

        drive(1'b0, 32'h0020A423, 32'h100, 32'hCAFEF00D, 32'd8);
        drive(1'b0, 32'hFFFFFFFF, 32'h100, 32'd8, 32'd8);
        check("ill_ctl", {22'd0, branch, memread, memtoreg, alusrc, memwrite, regwrite, aluctrl}, 32'd0);
        drive(1'b0, 32'h0080A183, 32'h100, 32'd0, 32'd8);
        check("ill_noram", mem_rdata, 32'hCAFEF00D);

        for (int i = 0; i < NVEC; i++) begin
            drive(1'b0, V_INS[i], V_A[i], V_B[i], V_IMM[i]);
            check($sformatf("vec%0d_y", i), alu_y, V_Y[i]);
        end

        @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
